frame_aligner_multi: RTL and testbench



---
 rtl/frame_aligner_multi_pkg.sv | 25 ++
 rtl/frame_aligner_hdr_matcher.sv | 54 +++++
 rtl/frame_aligner_multi.sv | 193 +++++++++++++++++++
 tb/tb_frame_aligner_multi.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_aligner_multi_pkg.sv
// Shared types and defaults for the multi-header frame aligner.
// Header constants put the first-received byte in the MSBs.
package frame_aligner_multi_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   typedef enum logic {
      HDR_TYPE_A = 1'b0,
      HDR_TYPE_B = 1'b1
   } hdr_type_e;

   localparam int          DEF_HDR_BYTES = 2;
   localparam logic [15:0] DEF_HDR_A     = 16'hAFAA;
   localparam logic [15:0] DEF_HDR_B     = 16'hBA55;

   // Index width that stays legal when the range holds a single value.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_aligner_hdr_matcher.sv
// Header window over the accepted byte stream, compared against both patterns.
// The window is the stored history plus the byte being accepted; matches are combinational.
module frame_aligner_hdr_matcher
   import frame_aligner_multi_pkg::*;
#(
   parameter int                     HDR_BYTES = DEF_HDR_BYTES,
   parameter logic [8*HDR_BYTES-1:0] HDR_A     = DEF_HDR_A,
   parameter logic [8*HDR_BYTES-1:0] HDR_B     = DEF_HDR_B
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       accept,
   input  logic [7:0] rx_data,
   output logic       match_a,
   output logic       match_b
);

   localparam int HW = 8 * HDR_BYTES;

   logic [HW-1:0] window;

   generate
      if (HDR_BYTES == 1) begin : g_single
         assign window = rx_data;
      end else begin : g_multi
         // Only the older HDR_BYTES-1 bytes need storing; the newest is rx_data itself.
         logic [HW-9:0] hist_q;
         logic [HW-9:0] hist_d;

         always_comb begin
            hist_d = hist_q;
            if (accept) begin
               hist_d = window[HW-9:0];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               hist_q <= '0;
            end else begin
               hist_q <= hist_d;
            end
         end

         assign window = {hist_q, rx_data};
      end
   endgenerate

   always_comb begin
      match_a = accept && (window == HDR_A);
      match_b = accept && (window == HDR_B);
   end

endmodule

// File: rtl/frame_aligner_multi.sv
// Frame aligner with two header types and lock/unlock hysteresis on a valid-qualified byte stream.
// Outputs are registered (1-cycle latency); optional FRAME_ALIGNER_STATS_EN adds header statistics.
module frame_aligner_multi
   import frame_aligner_multi_pkg::*;
#(
   parameter int                     HDR_BYTES     = DEF_HDR_BYTES,
   parameter logic [8*HDR_BYTES-1:0] HDR_A         = DEF_HDR_A,
   parameter logic [8*HDR_BYTES-1:0] HDR_B         = DEF_HDR_B,
   parameter int                     PAYLOAD_BYTES = 10,
   parameter int                     LOCK_FRAMES   = 3,
   parameter int                     UNLOCK_FRAMES = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            rx_valid,
   input  logic [7:0]                      rx_data,
   output logic                            frame_detect,
   output logic [idx_w(PAYLOAD_BYTES)-1:0] fr_byte_position,
   output logic                            sof,
   output logic                            hdr_type
`ifdef FRAME_ALIGNER_STATS_EN
   ,
   output logic [15:0]                     good_frames,
   output logic [15:0]                     bad_hdrs
`endif
);

   localparam int FRAME_LEN = HDR_BYTES + PAYLOAD_BYTES;
   localparam int PSW       = idx_w(FRAME_LEN);
   localparam int PW        = idx_w(PAYLOAD_BYTES);
   localparam int CNT_MAX   = (LOCK_FRAMES > UNLOCK_FRAMES) ? LOCK_FRAMES : UNLOCK_FRAMES;
   localparam int CW        = $clog2(CNT_MAX + 1);

   localparam logic [PSW-1:0] LAST_POS  = PSW'(FRAME_LEN - 1);
   localparam logic [PSW-1:0] PAYLOAD_N = PSW'(PAYLOAD_BYTES);
   localparam logic [CW-1:0]  LOCK_N    = CW'(LOCK_FRAMES);
   localparam logic [CW-1:0]  UNLOCK_N  = CW'(UNLOCK_FRAMES);

   state_e         state_q, state_d;
   logic [PSW-1:0] pos_q, pos_d;
   logic [CW-1:0]  good_cnt_q, good_cnt_d;
   logic [CW-1:0]  bad_cnt_q, bad_cnt_d;
   logic [PW-1:0]  fr_pos_q, fr_pos_d;
   logic           sof_q, sof_d;
   hdr_type_e      hdr_type_q, hdr_type_d;

   logic           match_a, match_b, hdr_match;
   logic [PSW-1:0] pos_inc;
   logic           boundary;

   frame_aligner_hdr_matcher #(
      .HDR_BYTES (HDR_BYTES),
      .HDR_A     (HDR_A),
      .HDR_B     (HDR_B)
   ) u_matcher (
      .clk     (clk),
      .reset   (reset),
      .accept  (rx_valid),
      .rx_data (rx_data),
      .match_a (match_a),
      .match_b (match_b)
   );

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      fr_pos_d   = fr_pos_q;
      sof_d      = 1'b0;
      hdr_type_d = hdr_type_q;

      hdr_match = match_a | match_b;
      // pos_inc is the frame position of the byte being accepted.
      pos_inc   = (pos_q == LAST_POS) ? '0 : pos_q + PSW'(1);
      boundary  = (pos_inc == LAST_POS);

      if (rx_valid) begin
         pos_d    = pos_inc;
         fr_pos_d = '0;
         if ((state_q == LOCKED) && (pos_inc < PAYLOAD_N)) begin
            fr_pos_d = PW'(pos_inc);
            sof_d    = (pos_inc == '0);
         end

         case (state_q)
            SEARCH: begin
               if (hdr_match) begin
                  pos_d      = LAST_POS;
                  good_cnt_d = CW'(1);
                  bad_cnt_d  = '0;
                  hdr_type_d = match_b ? HDR_TYPE_B : HDR_TYPE_A;
                  state_d    = (LOCK_FRAMES == 1) ? LOCKED : CONFIRM;
               end
            end
            CONFIRM: begin
               if (boundary) begin
                  if (hdr_match) begin
                     good_cnt_d = good_cnt_q + CW'(1);
                     hdr_type_d = match_b ? HDR_TYPE_B : HDR_TYPE_A;
                     if (good_cnt_d == LOCK_N) begin
                        state_d   = LOCKED;
                        bad_cnt_d = '0;
                     end
                  end else begin
                     state_d    = SEARCH;
                     good_cnt_d = '0;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  if (hdr_match) begin
                     bad_cnt_d  = '0;
                     hdr_type_d = match_b ? HDR_TYPE_B : HDR_TYPE_A;
                  end else begin
                     bad_cnt_d = bad_cnt_q + CW'(1);
                     if (bad_cnt_d == UNLOCK_N) begin
                        state_d    = SEARCH;
                        bad_cnt_d  = '0;
                        good_cnt_d = '0;
                     end
                  end
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SEARCH;
         pos_q      <= '0;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         fr_pos_q   <= '0;
         sof_q      <= 1'b0;
         hdr_type_q <= HDR_TYPE_A;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         fr_pos_q   <= fr_pos_d;
         sof_q      <= sof_d;
         hdr_type_q <= hdr_type_d;
      end
   end

   assign frame_detect     = (state_q == LOCKED);
   assign fr_byte_position = fr_pos_q;
   assign sof              = sof_q;
   assign hdr_type         = hdr_type_q;

`ifdef FRAME_ALIGNER_STATS_EN
   logic [15:0] good_frames_q, good_frames_d;
   logic [15:0] bad_hdrs_q, bad_hdrs_d;
   logic        good_evt, bad_evt;

   // The header that completes the lock counts as the first good frame.
   always_comb begin
      good_evt      = rx_valid && hdr_match && (state_d == LOCKED) &&
                      ((state_q != LOCKED) || boundary);
      bad_evt       = rx_valid && boundary && !hdr_match &&
                      ((state_q == LOCKED) || (state_q == CONFIRM));
      good_frames_d = good_frames_q;
      bad_hdrs_d    = bad_hdrs_q;
      if (good_evt && (good_frames_q != 16'hFFFF)) begin
         good_frames_d = good_frames_q + 16'd1;
      end
      if (bad_evt && (bad_hdrs_q != 16'hFFFF)) begin
         bad_hdrs_d = bad_hdrs_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         good_frames_q <= '0;
         bad_hdrs_q    <= '0;
      end else begin
         good_frames_q <= good_frames_d;
         bad_hdrs_q    <= bad_hdrs_d;
      end
   end

   assign good_frames = good_frames_q;
   assign bad_hdrs    = bad_hdrs_q;
`endif

endmodule

// File: tb/tb_frame_aligner_multi.sv
// Bench for frame_aligner_multi: directed vector table, hand sequences and random traffic
// checked against a stream-index reference model; stats checks run when FRAME_ALIGNER_STATS_EN is set.
module tb_frame_aligner_multi;

   localparam int          PB    = 10;
   localparam int          FL    = 12;
   localparam int          LOCKN = 3;
   localparam int          UNLKN = 4;
   localparam logic [15:0] H_A   = 16'hAFAA;
   localparam logic [15:0] H_B   = 16'hBA55;
   localparam logic [15:0] H_BAD = 16'hAEAB;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       frame_detect;
   logic [3:0] fr_byte_position;
   logic       sof;
   logic       hdr_type;
`ifdef FRAME_ALIGNER_STATS_EN
   logic [15:0] good_frames;
   logic [15:0] bad_hdrs;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   frame_aligner_multi dut (
      .clk              (clk),
      .reset            (reset),
      .rx_valid         (rx_valid),
      .rx_data          (rx_data),
      .frame_detect     (frame_detect),
      .fr_byte_position (fr_byte_position),
      .sof              (sof),
      .hdr_type         (hdr_type)
`ifdef FRAME_ALIGNER_STATS_EN
      ,
      .good_frames      (good_frames),
      .bad_hdrs         (bad_hdrs)
`endif
   );

   // Reference model: tracks absolute indices of accepted bytes and of the last header end.
   int         m_mode;   // 0 hunting, 1 confirming, 2 locked
   int         m_good, m_bad, m_idx, m_bnd;
   logic [7:0] m_hist[$];
   logic       e_fd, e_sof, e_type;
   int         e_pos;

   task automatic model_step(input logic rst, input logic v, input logic [7:0] d);
      logic [15:0] win;
      logic        is_a, is_b, at_bnd;
      int          rel;
      if (rst) begin
         m_mode = 0; m_good = 0; m_bad = 0; m_idx = 0; m_bnd = 0;
         m_hist.delete();
         e_pos = 0; e_sof = 1'b0; e_type = 1'b0;
      end else if (!v) begin
         e_sof = 1'b0;
      end else begin
         m_hist.push_back(d);
         if (m_hist.size() > 2) void'(m_hist.pop_front());
         win = '0;
         foreach (m_hist[i]) win = {win[7:0], m_hist[i]};
         is_a = (win == H_A);
         is_b = (win == H_B);
         e_pos = 0;
         e_sof = 1'b0;
         if (m_mode == 2) begin
            rel = m_idx - m_bnd - 1;
            if (rel < PB) begin
               e_pos = rel;
               e_sof = (rel == 0);
            end
         end
         at_bnd = (m_idx - m_bnd) == FL;
         if (m_mode == 0) begin
            if (is_a || is_b) begin
               m_bnd = m_idx; m_good = 1; e_type = is_b;
               m_mode = (LOCKN == 1) ? 2 : 1;
            end
         end else if (m_mode == 1) begin
            if (at_bnd) begin
               if (is_a || is_b) begin
                  m_bnd = m_idx; m_good++; e_type = is_b;
                  if (m_good == LOCKN) begin m_mode = 2; m_bad = 0; end
               end else begin
                  m_mode = 0;
               end
            end
         end else if (at_bnd) begin
            m_bnd = m_idx;
            if (is_a || is_b) begin
               m_bad = 0; e_type = is_b;
            end else begin
               m_bad++;
               if (m_bad == UNLKN) m_mode = 0;
            end
         end
         m_idx++;
      end
      e_fd = (m_mode == 2);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic step_raw(input logic rst, input logic v, input logic [7:0] d);
      reset    = rst;
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      model_step(rst, v, d);
      #1;
   endtask

   task automatic step(input logic rst, input logic v, input logic [7:0] d);
      step_raw(rst, v, d);
      chk("model_frame_detect", 32'(frame_detect), 32'(e_fd));
      chk("model_byte_pos", 32'(fr_byte_position), 32'(e_pos));
      chk("model_sof", 32'(sof), 32'(e_sof));
      chk("model_hdr_type", 32'(hdr_type), 32'(e_type));
   endtask

   // Idle cycles with probability pct before each accepted byte.
   task automatic put(input logic [7:0] d, input int pct);
      for (int g = 0; g < 6; g++) begin
         if ($urandom_range(0, 99) >= pct) break;
         step(1'b0, 1'b0, 8'($urandom));
         chk("sof_on_idle", 32'(sof), 32'd0);
      end
      step(1'b0, 1'b1, d);
   endtask

   task automatic send_frame(input logic [15:0] h, input int pct);
      put(h[15:8], pct);
      put(h[7:0], pct);
      for (int k = 0; k < PB; k++) put(8'h10 + 8'(k), pct);
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       fd;
      logic [3:0] pos;
      logic       sof;
      logic       typ;
   } vec_t;

   vec_t tbl[4*FL];

   initial begin
      // Four clean HDR_A frames; lock is expected after the header of the third.
      for (int f = 0; f < 4; f++) begin
         for (int b = 0; b < FL; b++) begin
            vec_t r;
            r.v   = 1'b1;
            r.d   = (b == 0) ? H_A[15:8] : (b == 1) ? H_A[7:0] : 8'h10 + 8'(b - 2);
            r.fd  = (f > 2) || (f == 2 && b >= 1);
            r.pos = (f >= 2 && b >= 2) ? 4'(b - 2) : 4'd0;
            r.sof = (f >= 2 && b == 2);
            r.typ = 1'b0;
            tbl[f*FL + b] = r;
         end
      end

      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      step_raw(1'b1, 1'b0, 8'h00);
      step_raw(1'b1, 1'b1, 8'hAF);
      chk("reset_frame_detect", 32'(frame_detect), 32'd0);
      chk("reset_byte_pos", 32'(fr_byte_position), 32'd0);
      chk("reset_sof", 32'(sof), 32'd0);
      chk("reset_hdr_type", 32'(hdr_type), 32'd0);

      foreach (tbl[i]) begin
         step_raw(1'b0, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_frame_detect", i), 32'(frame_detect), 32'(tbl[i].fd));
         chk($sformatf("tbl%0d_byte_pos", i), 32'(fr_byte_position), 32'(tbl[i].pos));
         chk($sformatf("tbl%0d_sof", i), 32'(sof), 32'(tbl[i].sof));
         chk($sformatf("tbl%0d_hdr_type", i), 32'(hdr_type), 32'(tbl[i].typ));
      end

      // Three bad headers then a good one: lock holds throughout.
      for (int f = 0; f < 3; f++) begin
         send_frame(H_BAD, 0);
         chk("flywheel_hold", 32'(frame_detect), 32'd1);
      end
      send_frame(H_A, 0);
      chk("flywheel_recover", 32'(frame_detect), 32'd1);

      // Four consecutive bad headers: lock drops on the 4th boundary byte.
      for (int f = 0; f < 3; f++) send_frame(H_BAD, 0);
      step(1'b0, 1'b1, H_BAD[15:8]);
      chk("unlock_before_4th", 32'(frame_detect), 32'd1);
      step(1'b0, 1'b1, H_BAD[7:0]);
      chk("unlock_after_4th", 32'(frame_detect), 32'd0);
      for (int k = 0; k < PB; k++) step(1'b0, 1'b1, 8'h10 + 8'(k));

      // Relock, then mixed header types.
      for (int f = 0; f < 3; f++) send_frame(H_A, 0);
      chk("relock", 32'(frame_detect), 32'd1);
      send_frame(H_B, 0);
      send_frame(H_A, 0);
      step(1'b0, 1'b1, H_B[15:8]);
      step(1'b0, 1'b1, H_B[7:0]);
      chk("mixed_type_b", 32'(hdr_type), 32'd1);
      for (int k = 0; k < PB; k++) step(1'b0, 1'b1, 8'h10 + 8'(k));
      step(1'b0, 1'b1, H_A[15:8]);
      step(1'b0, 1'b1, H_A[7:0]);
      chk("mixed_type_a", 32'(hdr_type), 32'd0);
      chk("mixed_lock", 32'(frame_detect), 32'd1);
      for (int k = 0; k < PB; k++) step(1'b0, 1'b1, 8'h10 + 8'(k));

      // Overlapping start AF AF AA must be found on the first frame.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hAF);
      for (int k = 0; k < PB; k++) step(1'b0, 1'b1, k == 0 ? 8'hAF : 8'h10);
      // The loop above sent AF then nine 0x10; realign to a clean overlap test.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hAF);
      step(1'b0, 1'b1, 8'hAF);
      step(1'b0, 1'b1, 8'hAA);
      for (int k = 0; k < PB; k++) step(1'b0, 1'b1, 8'h10 + 8'(k));
      send_frame(H_A, 0);
      step(1'b0, 1'b1, H_A[15:8]);
      step(1'b0, 1'b1, H_A[7:0]);
      chk("overlap_lock", 32'(frame_detect), 32'd1);

      // Reset mid-payload while locked.
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'h10 + 8'(k));
      step(1'b1, 1'b1, 8'h15);
      chk("midreset_frame_detect", 32'(frame_detect), 32'd0);
      chk("midreset_byte_pos", 32'(fr_byte_position), 32'd0);
      chk("midreset_sof", 32'(sof), 32'd0);
      chk("midreset_hdr_type", 32'(hdr_type), 32'd0);
      for (int f = 0; f < 2; f++) send_frame(H_B, 0);
      chk("midreset_no_early_lock", 32'(frame_detect), 32'd0);
      step(1'b0, 1'b1, H_B[15:8]);
      step(1'b0, 1'b1, H_B[7:0]);
      chk("midreset_relock", 32'(frame_detect), 32'd1);
      for (int k = 0; k < PB; k++) step(1'b0, 1'b1, 8'h10 + 8'(k));

      // Clean stream with ~30% idle cycles.
      step(1'b1, 1'b0, 8'h00);
      for (int f = 0; f < 8; f++) send_frame(H_A, 30);
      chk("gaps_locked", 32'(frame_detect), 32'd1);

      // Random traffic: random headers, corruption, payload bytes and gaps.
      step(1'b1, 1'b0, 8'h00);
      for (int f = 0; f < 250; f++) begin
         int          sel;
         logic [15:0] h;
         sel = int'($urandom_range(0, 99));
         h   = (sel < 45) ? H_A : (sel < 80) ? H_B : 16'($urandom);
         put(h[15:8], 20);
         put(h[7:0], 20);
         for (int k = 0; k < PB; k++) put(8'($urandom), 20);
         if ($urandom_range(0, 99) < 5) put(8'($urandom), 0);
      end

`ifdef FRAME_ALIGNER_STATS_EN
      step(1'b1, 1'b0, 8'h00);
      chk("stats_reset_good", 32'(good_frames), 32'd0);
      chk("stats_reset_bad", 32'(bad_hdrs), 32'd0);
      for (int f = 0; f < 10; f++) send_frame(H_A, 0);
      for (int f = 0; f < 2; f++) send_frame(H_BAD, 0);
      chk("stats_good_frames", 32'(good_frames), 32'd8);
      chk("stats_bad_hdrs", 32'(bad_hdrs), 32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
